// File: rtl/systolic_serial_pkg.sv
// Shared defaults, frame sizing and the tx state encoding for the systolic operand serializer.
package systolic_serial_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int N_DEF      = 4;

  function automatic int frame_bits(input int n, input int w);
    return n * n * w;
  endfunction

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_e;

endpackage

// File: rtl/serial_bit_timer.sv
// Half-period timer for the serial clock: counts CLK_DIV system cycles per half period and flags
// whether the wrap is a rising or falling serial-clock edge. Held cleared while disabled.
module serial_bit_timer #(
  parameter int CLK_DIV = 1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en_i,
  output logic rise_tick_o,
  output logic fall_tick_o
);

  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          phase_q, phase_d;
  logic          wrap;

  assign wrap = en_i && (hcnt_q == HW'(CLK_DIV - 1));

  // phase_q mirrors the serial clock level so a wrap can be classified as rise or fall
  always_comb begin
    hcnt_d  = hcnt_q;
    phase_d = phase_q;
    if (!en_i) begin
      hcnt_d  = '0;
      phase_d = 1'b0;
    end else if (wrap) begin
      hcnt_d  = '0;
      phase_d = ~phase_q;
    end else begin
      hcnt_d  = hcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      hcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      hcnt_q  <= hcnt_d;
      phase_q <= phase_d;
    end
  end

  assign rise_tick_o = wrap && !phase_q;
  assign fall_tick_o = wrap &&  phase_q;

endmodule

// File: rtl/systolic_serial_tx.sv
// Parallel-in, frame-synchronous serial-out operand serializer: element-major, MSB-first,
// data launched on the falling serial-clock edge so the receiver samples mid-bit on the rise.
module systolic_serial_tx
  import systolic_serial_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int N       = N_DEF,
  parameter int CLK_DIV = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    mat_valid_i,
  output logic                    mat_ready_o,
  input  logic [N*N*DATA_W-1:0]   mat_data_i,
  output logic                    ser_data_o,
  output logic                    ser_clk_o,
  output logic                    ser_frame_sync_o,
  output logic                    busy_o,
  output logic                    frame_done_o
);

  localparam int FB = frame_bits(N, DATA_W);
  localparam int BW = (FB > 1) ? $clog2(FB) : 1;

  // Reorder so the stream's first bit (element 0, MSB) sits at the top of the shift register
  function automatic logic [FB-1:0] to_stream(input logic [FB-1:0] m);
    logic [FB-1:0] s;
    s = '0;
    for (int k = 0; k < N * N; k++) begin
      for (int j = 0; j < DATA_W; j++) begin
        s[FB - DATA_W - k * DATA_W + j] = m[k * DATA_W + j];
      end
    end
    return s;
  endfunction

  tx_state_e     state_q, state_d;
  logic [FB-1:0] shreg_q, shreg_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          ser_data_q, ser_data_d;
  logic          ser_clk_q, ser_clk_d;
  logic          sync_q, sync_d;
  logic          done_q, done_d;

  logic [FB-1:0] stream;
  logic          accept;
  logic          rise_tick, fall_tick;
  logic          last_fall;

  assign stream    = to_stream(mat_data_i);
  assign accept    = mat_valid_i && (state_q == IDLE);
  assign last_fall = fall_tick && (bcnt_q == BW'(FB - 1));

  serial_bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .en_i        (state_q == SHIFT),
    .rise_tick_o (rise_tick),
    .fall_tick_o (fall_tick)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = SHIFT;
      SHIFT:   if (last_fall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mat_ready_o = (state_q == IDLE);
    busy_o      = (state_q == SHIFT);
  end

  always_comb begin
    shreg_d    = shreg_q;
    bcnt_d     = bcnt_q;
    ser_data_d = ser_data_q;
    ser_clk_d  = ser_clk_q;
    sync_d     = sync_q;
    done_d     = 1'b0;
    if (state_q == IDLE) begin
      ser_clk_d  = 1'b0;
      ser_data_d = 1'b0;
      sync_d     = 1'b0;
      bcnt_d     = '0;
      if (accept) begin
        shreg_d    = stream;
        ser_data_d = stream[FB-1];
        sync_d     = 1'b1;
      end
    end else begin
      if (rise_tick) ser_clk_d = 1'b1;
      if (fall_tick) begin
        ser_clk_d = 1'b0;
        sync_d    = 1'b0;
        if (last_fall) begin
          ser_data_d = 1'b0;
          shreg_d    = '0;
          bcnt_d     = '0;
          done_d     = 1'b1;
        end else begin
          ser_data_d = shreg_q[FB-2];
          shreg_d    = shreg_q << 1;
          bcnt_d     = bcnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      shreg_q    <= '0;
      bcnt_q     <= '0;
      ser_data_q <= 1'b0;
      ser_clk_q  <= 1'b0;
      sync_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      shreg_q    <= shreg_d;
      bcnt_q     <= bcnt_d;
      ser_data_q <= ser_data_d;
      ser_clk_q  <= ser_clk_d;
      sync_q     <= sync_d;
      done_q     <= done_d;
    end
  end

  assign ser_data_o       = ser_data_q;
  assign ser_clk_o        = ser_clk_q;
  assign ser_frame_sync_o = sync_q;
  assign frame_done_o     = done_q;

endmodule

// File: tb/tb_systolic_serial_tx.sv
// Directed bench for systolic_serial_tx: one instance at CLK_DIV=1, one at CLK_DIV=3,
// with a rising-edge deserializer recovering each frame.
module tb_systolic_serial_tx;

  localparam int DW = 8;
  localparam int NN = 4;
  localparam int FB = NN * NN * DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          v1, v3;
  logic [FB-1:0] d1, d3;
  logic          r1, sd1, sc1, fs1, b1, fd1;
  logic          r3, sd3, sc3, fs3, b3, fd3;

  systolic_serial_tx #(.DATA_W(DW), .N(NN), .CLK_DIV(1)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .mat_valid_i(v1), .mat_ready_o(r1), .mat_data_i(d1),
    .ser_data_o(sd1), .ser_clk_o(sc1), .ser_frame_sync_o(fs1), .busy_o(b1), .frame_done_o(fd1)
  );

  systolic_serial_tx #(.DATA_W(DW), .N(NN), .CLK_DIV(3)) dut3 (
    .clk_i(clk), .rst_n_i(rst_n), .mat_valid_i(v3), .mat_ready_o(r3), .mat_data_i(d3),
    .ser_data_o(sd3), .ser_clk_o(sc3), .ser_frame_sync_o(fs3), .busy_o(b3), .frame_done_o(fd3)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [FB-1:0] mat_a, mat_b, exp_a, exp_b;

  logic [FB-1:0] cap_bits;
  int            cap_done, cap_rises, cap_sync, cap_bad_data, cap_bad_run;
  logic          cap_sync_c1;

  // Expected serial order: element 0 first, MSB first within each element
  function automatic logic [FB-1:0] exp_stream(input logic [FB-1:0] m);
    logic [FB-1:0] r;
    int idx;
    idx = FB - 1;
    for (int k = 0; k < NN * NN; k++) begin
      for (int b = DW - 1; b >= 0; b--) begin
        r[idx] = m[k * DW + b];
        idx--;
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [FB-1:0] got, input logic [FB-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic start(input bit sel, input logic [FB-1:0] m);
    @(negedge clk);
    n_cmp++;
    if ((sel ? r3 : r1) !== 1'b1) begin
      n_err++;
      $display("FAIL start_ready: got %b expected 1", sel ? r3 : r1);
    end
    if (sel) begin d3 = m; v3 = 1'b1; end
    else     begin d1 = m; v1 = 1'b1; end
    @(posedge clk);
  endtask

  // mode 0: drop valid at c=1; mode 1: scribble data and pulse valid while busy;
  // mode 2: present next_mat and keep valid high for a back-to-back accept
  task automatic capture(input bit sel, input int mode, input logic [FB-1:0] next_mat, input int budget);
    logic pc, pd, c_clk, c_dat, c_fs, c_fd;
    int   run, div;
    cap_bits = '0; cap_done = -1; cap_rises = 0; cap_sync = 0;
    cap_bad_data = 0; cap_bad_run = 0; cap_sync_c1 = 1'b0;
    pc = 1'b0; pd = 1'b0; run = 0; div = sel ? 3 : 1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (mode == 2) begin
          if (sel) d3 = next_mat; else d1 = next_mat;
        end else begin
          if (sel) v3 = 1'b0; else v1 = 1'b0;
        end
        if (mode == 1) d1 = '1;
      end
      if (mode == 1 && c == 10) v1 = 1'b1;
      if (mode == 1 && c == 11) v1 = 1'b0;
      c_clk = sel ? sc3 : sc1;
      c_dat = sel ? sd3 : sd1;
      c_fs  = sel ? fs3 : fs1;
      c_fd  = sel ? fd3 : fd1;
      if (c == 1) cap_sync_c1 = c_fs;
      if (c_fs) cap_sync++;
      if (c_clk && !pc) begin
        if (cap_rises < FB) cap_bits[FB - 1 - cap_rises] = c_dat;
        cap_rises++;
      end
      if (c > 1 && c_dat !== pd && !(pc && !c_clk)) cap_bad_data++;
      if (c_clk == pc) run++;
      else begin
        if (run != div) cap_bad_run++;
        run = 1;
      end
      pc = c_clk;
      pd = c_dat;
      if (c_fd) begin
        cap_done = c;
        break;
      end
    end
    if (cap_done < 0) $display("FAIL capture_timeout: no frame_done within %0d cycles", budget);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; v1 = 1'b0; v3 = 1'b0; d1 = '0; d3 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready",    FB'(r1),  FB'(1));
    chk("reset_ser_data", FB'(sd1), FB'(0));
    chk("reset_ser_clk",  FB'(sc1), FB'(0));
    chk("reset_sync",     FB'(fs1), FB'(0));
    chk("reset_busy",     FB'(b1),  FB'(0));
    chk("reset_done",     FB'(fd1), FB'(0));
    chk("reset_ready3",   FB'(r3),  FB'(1));
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_frame;
    start(0, mat_a);
    capture(0, 0, '0, 600);
    chk("single_first8",  FB'(cap_bits[FB-1:FB-8]), FB'(8'hA5));
    chk("single_last8",   FB'(cap_bits[7:0]),       FB'(8'h81));
    chk("single_frame",   cap_bits,                 exp_a);
    chk("single_sync_c1", FB'(cap_sync_c1),         FB'(1));
    chk("single_sync_n",  FB'(cap_sync),            FB'(2));
    chk("single_len",     FB'(cap_done),            FB'(257));
    chk("single_rises",   FB'(cap_rises),           FB'(128));
    chk("single_datafall",FB'(cap_bad_data),        FB'(0));
    chk("done_ready",     FB'(r1),                  FB'(1));
    chk("done_busy",      FB'(b1),                  FB'(0));
    chk("done_ser",       FB'({sc1, sd1}),          FB'(0));
    @(negedge clk);
    chk("done_pulse_1cyc", FB'(fd1), FB'(0));
  endtask

  task automatic test_data_capture;
    int busy_after;
    start(0, mat_b);
    capture(0, 1, '0, 600);
    chk("capture_frame", cap_bits,       exp_b);
    chk("capture_len",   FB'(cap_done),  FB'(257));
    busy_after = 0;
    repeat (20) begin
      @(negedge clk);
      if (b1 || fs1 || sc1) busy_after++;
    end
    chk("capture_no_second", FB'(busy_after), FB'(0));
  endtask

  task automatic test_back_to_back;
    logic [FB-1:0] first_bits;
    start(0, mat_a);
    capture(0, 2, mat_b, 600);
    first_bits = cap_bits;
    chk("b2b_first_len",   FB'(cap_done), FB'(257));
    chk("b2b_ready_done",  FB'(r1),       FB'(1));
    capture(0, 0, '0, 600);
    chk("b2b_first_frame", first_bits,        exp_a);
    chk("b2b_sync_next",   FB'(cap_sync_c1),  FB'(1));
    chk("b2b_second",      cap_bits,          exp_b);
    chk("b2b_second_len",  FB'(cap_done),     FB'(257));
    @(negedge clk);
  endtask

  task automatic test_clk_div3;
    start(1, mat_b);
    capture(1, 0, '0, 2000);
    chk("div3_len",      FB'(cap_done),     FB'(769));
    chk("div3_halfper",  FB'(cap_bad_run),  FB'(0));
    chk("div3_datafall", FB'(cap_bad_data), FB'(0));
    chk("div3_rises",    FB'(cap_rises),    FB'(128));
    chk("div3_sync_n",   FB'(cap_sync),     FB'(6));
    chk("div3_frame",    cap_bits,          exp_b);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame;
    int done_seen;
    start(0, mat_a);
    @(negedge clk);
    v1 = 1'b0;
    repeat (80) @(negedge clk);
    chk("mid_busy_before", FB'(b1), FB'(1));
    rst_n = 1'b0;
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (fd1) done_seen++;
    end
    chk("mid_rst_ready", FB'(r1),              FB'(1));
    chk("mid_rst_outs",  FB'({sd1, sc1, fs1}), FB'(0));
    chk("mid_rst_busy",  FB'(b1),              FB'(0));
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (fd1 || b1) done_seen++;
    end
    chk("mid_no_done", FB'(done_seen), FB'(0));
    start(0, mat_b);
    capture(0, 0, '0, 600);
    chk("mid_new_sync",  FB'(cap_sync_c1), FB'(1));
    chk("mid_new_frame", cap_bits,         exp_b);
    chk("mid_new_len",   FB'(cap_done),    FB'(257));
  endtask

  initial begin
    mat_a = '0;
    mat_a[7:0]       = 8'hA5;
    mat_a[FB-1:FB-8] = 8'h81;
    for (int k = 0; k < NN * NN; k++) mat_b[k*DW +: DW] = 8'(k * 16 + (15 - k));
    exp_a = exp_stream(mat_a);
    exp_b = exp_stream(mat_b);

    test_reset();
    test_single_frame();
    test_data_capture();
    test_back_to_back();
    test_clk_div3();
    test_reset_mid_frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
